paddle_ctrl: RTL

//  Converts one player's 4-bit keypad keycode into a paddle vertical position for the VGA renderer.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/paddle_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Constants shared by the pong paddle, ball and vga logic.
// Holds the playfield geometry, the keypad codes and the paddle FSM state encodings.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 64;
    localparam int Y_CTR    = (SCREEN_H - PADDLE_H) / 2;

    localparam logic [3:0] UP_CODE = 4'h2;
    localparam logic [3:0] DN_CODE = 4'h8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DN   = 2'd2;

    // Every keycode other than the two motion codes means "stay still".
    function automatic logic [1:0] code_to_state(
        input logic [3:0] code,
        input logic [3:0] up_code,
        input logic [3:0] dn_code
    );
        if (code == up_code) begin
            return ST_UP;
        end else if (code == dn_code) begin
            return ST_DN;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Accepts a code only after it has been sampled unchanged for CYCLES+1 consecutive edges.
// o_changed pulses for one cycle when the accepted code takes a new value.
module key_debounce #(
    parameter int W      = 4,
    parameter int CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_code,
    output logic [W-1:0] o_code,
    output logic         o_changed
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [W-1:0]  r_sample;
    logic [W-1:0]  r_code;
    logic [CW-1:0] r_cnt;
    logic          r_changed;

    // The counter saturates at CNT_LAST, so a steady code is re-latched every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample  <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sample  <= i_code;
            r_changed <= 1'b0;
            if (i_code != r_sample) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_code    <= r_sample;
                r_changed <= (r_sample != r_code);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_code    = r_code;
    assign o_changed = r_changed;

endmodule

// File: rtl/paddle_ctrl.sv
// One player's paddle: debounced keycode drives an UP/DOWN/IDLE FSM that moves the
// paddle once per frame with an accelerating, clamped step.
module paddle_ctrl #(
    parameter int         SCREEN_H        = pong_pkg::SCREEN_H,
    parameter int         PADDLE_H        = pong_pkg::PADDLE_H,
    parameter logic [3:0] UP_CODE         = pong_pkg::UP_CODE,
    parameter logic [3:0] DN_CODE         = pong_pkg::DN_CODE,
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         STEP_MIN        = 2,
    parameter int         STEP_MAX        = 8,
    parameter int         ACCEL_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_keycode,
    input  logic       i_frame_tick,
    input  logic       i_center,
    output logic [9:0] o_paddle_y,
    output logic       o_moving_up,
    output logic       o_moving_dn,
    output logic       o_at_top,
    output logic       o_at_bot
);

    import pong_pkg::ST_IDLE;
    import pong_pkg::ST_UP;
    import pong_pkg::ST_DN;
    import pong_pkg::code_to_state;

    localparam int Y_MAX = SCREEN_H - PADDLE_H;
    localparam int Y_CTR = Y_MAX / 2;
    localparam int FW    = $clog2(ACCEL_FRAMES + 1);

    localparam logic [10:0]   Y_MAX_W    = 11'(Y_MAX);
    localparam logic [9:0]    Y_CTR_W    = 10'(Y_CTR);
    localparam logic [3:0]    STEP_MIN_W = 4'(STEP_MIN);
    localparam logic [3:0]    STEP_MAX_W = 4'(STEP_MAX);
    localparam logic [FW-1:0] ACCEL_W    = FW'(ACCEL_FRAMES);

    logic [3:0]    w_cmd;
    logic          w_cmd_changed;
    logic [1:0]    r_state;
    logic [1:0]    w_cmd_state;
    logic [1:0]    w_state_next;
    logic [9:0]    r_y;
    logic [9:0]    w_y_move;
    logic [10:0]   w_y_sub;
    logic [10:0]   w_y_add;
    logic [3:0]    r_step;
    logic [3:0]    w_step_inc;
    logic [FW-1:0] r_fc;
    logic [FW-1:0] w_fc_inc;
    logic          w_accel;

    key_debounce #(
        .W      (4),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_code    (i_keycode),
        .o_code    (w_cmd),
        .o_changed (w_cmd_changed)
    );

    // The FSM only drifts from the command after a recentre forces IDLE, so resync from IDLE too.
    always_comb begin
        w_cmd_state  = code_to_state(w_cmd, UP_CODE, DN_CODE);
        w_state_next = (w_cmd_changed || r_state == ST_IDLE) ? w_cmd_state : r_state;
        w_y_sub      = {1'b0, r_y} - {7'd0, r_step};
        w_y_add      = {1'b0, r_y} + {7'd0, r_step};
        w_y_move     = r_y;
        case (r_state)
            ST_UP:   w_y_move = ({1'b0, r_y} < {7'd0, r_step}) ? 10'd0 : w_y_sub[9:0];
            ST_DN:   w_y_move = (w_y_add > Y_MAX_W) ? Y_MAX_W[9:0] : w_y_add[9:0];
            default: w_y_move = r_y;
        endcase
        w_fc_inc   = r_fc + 1'b1;
        w_accel    = (w_fc_inc == ACCEL_W);
        w_step_inc = (r_step >= STEP_MAX_W) ? STEP_MAX_W : r_step + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= Y_CTR_W;
            r_step  <= STEP_MIN_W;
            r_fc    <= '0;
        end else if (i_center) begin
            r_state <= ST_IDLE;
            r_y     <= Y_CTR_W;
            r_step  <= STEP_MIN_W;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_next;
            if (i_frame_tick && r_state != ST_IDLE) begin
                r_y <= w_y_move;
                if (w_accel) begin
                    r_fc   <= '0;
                    r_step <= w_step_inc;
                end else begin
                    r_fc <= w_fc_inc;
                end
            end
            // A state change (to IDLE or a reversal) restarts acceleration and overrides the tick update.
            if (w_state_next != r_state) begin
                r_step <= STEP_MIN_W;
                r_fc   <= '0;
            end
        end
    end

    assign o_paddle_y  = r_y;
    assign o_moving_up = (r_state == ST_UP);
    assign o_moving_dn = (r_state == ST_DN);
    assign o_at_top    = (r_y == 10'd0);
    assign o_at_bot    = ({1'b0, r_y} == Y_MAX_W);

endmodule
